time_load_arbiter: RTL and testbench
====================================

Name: time_load_arbiter

Overview:
- Arbitrates the clock counter's single load port between the DCF77 decoder and the manual SetClock path.
- Validates the 44-bit BCD time/date word before loading it. Issues a one-cycle clock_set_out pulse and acknowledges the requester.
- Enforces a hold-off window after a manual set so DCF frames cannot immediately overwrite it.
- Sits between the DCF/SetClock sources and control_unit/clock counter.

Parameters:
- HOLDOFF_S, 60: hold-off length in clk_en pulses (seconds) after an accepted manual load; legal range 0..255.
- TD_W, 44: time/date word width; fixed layout.
  - Seconds: [3:0] lo, [6:4] hi.
  - Minutes: [10:7] lo, [13:11] hi.
  - Hours: [17:14] lo, [19:18] hi.
  - Day: [23:20] lo, [25:24] hi.
  - Month: [29:26] lo, [30] hi.
  - Year: [34:31] lo, [38:35] hi.
  - Weekday: [41:39]. Timezone: [43:42].

Ports:
- clk  in  1  system clock
- nReset  in  1  asynchronous active-low reset
- clk_en  in  1  1 Hz single-cycle enable
- DCF_Enable_in  in  1  DCF source permitted
- dcf_req_in  in  1  DCF load request; level, held until ack
- DCF_timeAndDate_in  in  44  DCF word
- dcf_ack_out  out  1  one-cycle ack to DCF
- set_req_in  in  1  manual load request; level, held until ack
- SetClock_timeAndDate_in  in  44  manual word
- set_ack_out  out  1  one-cycle ack to SetClock
- clock_set_out  out  1  one-cycle load strobe to clock counter
- clock_timeAndDate_Out  out  44  registered word; valid whenever clock_set_out=1, held afterwards
- source_out  out  2  last served source: 00 none, 01 DCF, 10 SET
- reject_out  out  1  one-cycle pulse when a request fails validation
- holdoff_active_out  out  1  high while the hold-off counter is nonzero

Behaviour:
- Reset (async, nReset=0): state IDLE. All outputs 0, including clock_timeAndDate_Out and source_out. Hold-off counter 0; latched word 0.
- Reset mid-operation aborts the current transaction with no strobe and no ack.
- FSM states: IDLE, CHECK, LOAD, REJECT, RELEASE.
- IDLE:
  - set_req_in=1: latch SetClock word, src=SET, go to CHECK.
  - Else if dcf_req_in=1 and DCF_Enable_in=1 and hold-off=0: latch DCF word, src=DCF, go to CHECK.
  - Else remain in IDLE. A blocked DCF request stays pending and is not acked.
- CHECK (1 cycle): registered validity evaluation.
  - Every BCD digit ≤ 9.
  - sec hi ≤ 5; min hi ≤ 5; hour ≤ 23 (hi=2 requires lo ≤ 3).
  - Day 01..31 (hi=3 requires lo ≤ 1; 00 illegal).
  - Month 01..12; weekday 1..7; year 00..99.
  - Valid → LOAD; invalid → REJECT.
- LOAD (1 cycle):
  - clock_set_out=1 and clock_timeAndDate_Out=latched word; source_out updated.
  - The matching ack is asserted in the same cycle.
  - If src=SET, load the hold-off counter with HOLDOFF_S.
  - Next state RELEASE.
- REJECT (1 cycle): reject_out=1 plus the matching ack. No strobe; clock_timeAndDate_Out and source_out unchanged. Next state RELEASE.
- RELEASE: wait until the served source's req is 0, then IDLE. The other source's request may be pending but is not served until IDLE.
- Latency: request seen high at edge N gives strobe/ack high in the cycle after edge N+2 (two clocks after acceptance).
- Simultaneous requests: SET wins. After a valid SET, the pending DCF request is blocked by hold-off. After a rejected SET, DCF is served on the next IDLE cycle.
- Hold-off counter:
  - Decrements on each clk_en while nonzero; saturates at 0.
  - A clk_en coinciding with a reload in LOAD is ignored; the reload wins.
  - HOLDOFF_S=0 disables hold-off.
- DCF_Enable_in=0: DCF requests are ignored entirely, with no ack. Deasserting it mid-transaction does not abort a DCF request already in CHECK or LOAD.
- Timezone bits are passed through unchecked.

Optional Feature:
- Macro TIME_LOAD_LEAP_CHECK_EN.
- Defined: CHECK also enforces days-per-month.
  - Apr/Jun/Sep/Nov ≤ 30.
  - Feb ≤ 28, or ≤ 29 when year%4==0. Year 00 counts as leap.
- Undefined: only the day range 01..31 is checked; 31.02 passes.

Test Plan:
- SET word 23:59:45, 31.12.19, weekday 2, with set_req_in held → clock_set_out and set_ack_out pulse once 2 clocks after acceptance. Required: clock_timeAndDate_Out equals the word, source_out=10, holdoff_active_out=1.
- With HOLDOFF_S=3: valid DCF request during hold-off → no dcf_ack_out. After 3 clk_en pulses, holdoff_active_out=0 and the DCF load completes with source_out=01.
- dcf_req_in and set_req_in rise in the same cycle with valid words → SET is served. DCF is not served until the hold-off expires and set_req_in returns low.
- DCF word with hour 24 or minute lo=0xA → reject_out and dcf_ack_out pulse. No clock_set_out; clock_timeAndDate_Out holds its previous value.
- DCF_Enable_in=0 with dcf_req_in=1 for 100 cycles → no ack and no strobe. Raising DCF_Enable_in produces the load.
- Leap-check macro defined: SET 29.02.19 → reject_out; SET 29.02.20 → clock_set_out. Macro undefined: 31.02.19 → clock_set_out.
- Reset asserted during CHECK → all outputs 0 immediately and no strobe. After release, a held request is re-served from IDLE.

Source files
------------

// File: rtl/time_load_arbiter.sv
// Arbitrates the clock counter load port between the DCF77 decoder and manual SetClock, validating the BCD word.
// Optional day-per-month/leap-year validation is enabled by defining TIME_LOAD_LEAP_CHECK_EN.
module time_load_arbiter #(
    parameter int HOLDOFF_S = 60,
    parameter int TD_W      = 44
) (
    input  logic            clk,
    input  logic            nReset,
    input  logic            clk_en,
    input  logic            DCF_Enable_in,
    input  logic            dcf_req_in,
    input  logic [TD_W-1:0] DCF_timeAndDate_in,
    output logic            dcf_ack_out,
    input  logic            set_req_in,
    input  logic [TD_W-1:0] SetClock_timeAndDate_in,
    output logic            set_ack_out,
    output logic            clock_set_out,
    output logic [TD_W-1:0] clock_timeAndDate_Out,
    output logic [1:0]      source_out,
    output logic            reject_out,
    output logic            holdoff_active_out
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CHECK   = 3'd1,
        ST_LOAD    = 3'd2,
        ST_REJECT  = 3'd3,
        ST_RELEASE = 3'd4
    } state_t;

    localparam logic [1:0] SRC_NONE     = 2'b00;
    localparam logic [1:0] SRC_DCF      = 2'b01;
    localparam logic [1:0] SRC_SET      = 2'b10;
    localparam logic [7:0] HOLDOFF_LOAD = 8'(HOLDOFF_S);

    // Timezone bits [43:42] are deliberately not part of the validated field.
    function automatic logic td_valid(input logic [41:0] w);
        logic [3:0] sec_lo, min_lo, hr_lo, day_lo, mon_lo, yr_lo, yr_hi;
        logic [2:0] sec_hi, min_hi, wday;
        logic [1:0] hr_hi, day_hi;
        logic       mon_hi;
        logic       ok;
`ifdef TIME_LOAD_LEAP_CHECK_EN
        logic [3:0] month_v;
        logic [5:0] day_v;
        logic       leap;
`endif
        sec_lo = w[3:0];    sec_hi = w[6:4];
        min_lo = w[10:7];   min_hi = w[13:11];
        hr_lo  = w[17:14];  hr_hi  = w[19:18];
        day_lo = w[23:20];  day_hi = w[25:24];
        mon_lo = w[29:26];  mon_hi = w[30];
        yr_lo  = w[34:31];  yr_hi  = w[38:35];
        wday   = w[41:39];
        ok = (sec_lo <= 4'd9) && (sec_hi <= 3'd5)
          && (min_lo <= 4'd9) && (min_hi <= 3'd5)
          && (hr_lo <= 4'd9) && (hr_hi <= 2'd2) && ((hr_hi != 2'd2) || (hr_lo <= 4'd3))
          && (day_lo <= 4'd9) && ((day_hi != 2'd3) || (day_lo <= 4'd1))
          && !((day_hi == 2'd0) && (day_lo == 4'd0))
          && (mon_lo <= 4'd9) && (!mon_hi || (mon_lo <= 4'd2))
          && !(!mon_hi && (mon_lo == 4'd0))
          && (yr_lo <= 4'd9) && (yr_hi <= 4'd9)
          && (wday != 3'd0);
`ifdef TIME_LOAD_LEAP_CHECK_EN
        month_v = mon_hi ? (4'd10 + mon_lo) : mon_lo;
        day_v   = (6'(day_hi) * 6'd10) + 6'(day_lo);
        // 10*hi mod 4 == 2*hi[0] mod 4, so the low year bits decide divisibility by 4.
        leap    = (2'({yr_hi[0], 1'b0}) + yr_lo[1:0]) == 2'b00;
        if (((month_v == 4'd4) || (month_v == 4'd6) || (month_v == 4'd9) || (month_v == 4'd11))
            && (day_v > 6'd30)) begin
            ok = 1'b0;
        end else if ((month_v == 4'd2) && (day_v > (leap ? 6'd29 : 6'd28))) begin
            ok = 1'b0;
        end else begin
            ok = ok;
        end
`endif
        return ok;
    endfunction

    state_t          state_r;
    logic [1:0]      src_r;
    logic [TD_W-1:0] word_r;
    logic [TD_W-1:0] td_out_r;
    logic [1:0]      source_r;
    logic            clock_set_r;
    logic            dcf_ack_r;
    logic            set_ack_r;
    logic            reject_r;
    logic [7:0]      holdoff_cnt_r;
    logic            holdoff_active_r;
    logic [7:0]      holdoff_nxt_s;
    logic            served_req_s;

    // Hold-off next value: a reload in LOAD takes priority over a coincident clk_en.
    always_comb begin
        holdoff_nxt_s = holdoff_cnt_r;
        if ((state_r == ST_LOAD) && (src_r == SRC_SET)) begin
            holdoff_nxt_s = HOLDOFF_LOAD;
        end else if (clk_en && (holdoff_cnt_r != 8'd0)) begin
            holdoff_nxt_s = holdoff_cnt_r - 8'd1;
        end else begin
            holdoff_nxt_s = holdoff_cnt_r;
        end
    end

    // Request line of whichever source is currently being served.
    always_comb begin
        served_req_s = 1'b0;
        if (src_r == SRC_SET) begin
            served_req_s = set_req_in;
        end else begin
            served_req_s = dcf_req_in;
        end
    end

    // Arbitration FSM with registered strobe, ack, reject and hold-off outputs.
    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            state_r          <= ST_IDLE;
            src_r            <= SRC_NONE;
            word_r           <= '0;
            td_out_r         <= '0;
            source_r         <= SRC_NONE;
            clock_set_r      <= 1'b0;
            dcf_ack_r        <= 1'b0;
            set_ack_r        <= 1'b0;
            reject_r         <= 1'b0;
            holdoff_cnt_r    <= 8'd0;
            holdoff_active_r <= 1'b0;
        end else begin
            clock_set_r      <= 1'b0;
            dcf_ack_r        <= 1'b0;
            set_ack_r        <= 1'b0;
            reject_r         <= 1'b0;
            holdoff_cnt_r    <= holdoff_nxt_s;
            holdoff_active_r <= (holdoff_nxt_s != 8'd0);
            case (state_r)
                ST_IDLE: begin
                    if (set_req_in) begin
                        word_r  <= SetClock_timeAndDate_in;
                        src_r   <= SRC_SET;
                        state_r <= ST_CHECK;
                    end else if (dcf_req_in && DCF_Enable_in && (holdoff_cnt_r == 8'd0)) begin
                        word_r  <= DCF_timeAndDate_in;
                        src_r   <= SRC_DCF;
                        state_r <= ST_CHECK;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_CHECK: begin
                    if (td_valid(word_r[41:0])) begin
                        state_r <= ST_LOAD;
                    end else begin
                        state_r <= ST_REJECT;
                    end
                end
                ST_LOAD: begin
                    clock_set_r <= 1'b1;
                    td_out_r    <= word_r;
                    source_r    <= src_r;
                    if (src_r == SRC_SET) begin
                        set_ack_r <= 1'b1;
                    end else begin
                        dcf_ack_r <= 1'b1;
                    end
                    state_r <= ST_RELEASE;
                end
                ST_REJECT: begin
                    reject_r <= 1'b1;
                    if (src_r == SRC_SET) begin
                        set_ack_r <= 1'b1;
                    end else begin
                        dcf_ack_r <= 1'b1;
                    end
                    state_r <= ST_RELEASE;
                end
                ST_RELEASE: begin
                    if (!served_req_s) begin
                        state_r <= ST_IDLE;
                    end else begin
                        state_r <= ST_RELEASE;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign clock_set_out         = clock_set_r;
    assign clock_timeAndDate_Out = td_out_r;
    assign source_out            = source_r;
    assign dcf_ack_out           = dcf_ack_r;
    assign set_ack_out           = set_ack_r;
    assign reject_out            = reject_r;
    assign holdoff_active_out    = holdoff_active_r;

endmodule

// File: tb/tb_time_load_arbiter.sv
// Directed bench for time_load_arbiter with HOLDOFF_S=3; expected values are hand-built BCD words.
module tb_time_load_arbiter;

    logic        clk = 1'b0;
    logic        nReset;
    logic        clk_en;
    logic        DCF_Enable_in;
    logic        dcf_req_in;
    logic [43:0] DCF_timeAndDate_in;
    logic        dcf_ack_out;
    logic        set_req_in;
    logic [43:0] SetClock_timeAndDate_in;
    logic        set_ack_out;
    logic        clock_set_out;
    logic [43:0] clock_timeAndDate_Out;
    logic [1:0]  source_out;
    logic        reject_out;
    logic        holdoff_active_out;

    int n_tests = 0;
    int n_fail  = 0;
    int n_strobe = 0;
    int n_dcf_ack = 0;
    int snap_a, snap_b;

    logic [43:0] w_set1, w_dcf1, w_bad_hr, w_bad_min, w_dcf2, w_set2, w_dcf3;
    logic [43:0] w_feb29_19, w_feb29_20, w_feb31_19, w_day00, w_set3;

    time_load_arbiter #(.HOLDOFF_S(3), .TD_W(44)) dut (
        .clk                     (clk),
        .nReset                  (nReset),
        .clk_en                  (clk_en),
        .DCF_Enable_in           (DCF_Enable_in),
        .dcf_req_in              (dcf_req_in),
        .DCF_timeAndDate_in      (DCF_timeAndDate_in),
        .dcf_ack_out             (dcf_ack_out),
        .set_req_in              (set_req_in),
        .SetClock_timeAndDate_in (SetClock_timeAndDate_in),
        .set_ack_out             (set_ack_out),
        .clock_set_out           (clock_set_out),
        .clock_timeAndDate_Out   (clock_timeAndDate_Out),
        .source_out              (source_out),
        .reject_out              (reject_out),
        .holdoff_active_out      (holdoff_active_out)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (clock_set_out) n_strobe <= n_strobe + 1;
        if (dcf_ack_out)   n_dcf_ack <= n_dcf_ack + 1;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    function automatic logic [43:0] mk_word(input logic [7:0] hh, input logic [7:0] mm,
                                            input logic [7:0] ss, input logic [7:0] dd,
                                            input logic [7:0] mo, input logic [7:0] yy,
                                            input logic [2:0] wd, input logic [1:0] tz);
        logic [43:0] w;
        w = 44'd0;
        w[3:0]   = ss[3:0];  w[6:4]   = ss[6:4];
        w[10:7]  = mm[3:0];  w[13:11] = mm[6:4];
        w[17:14] = hh[3:0];  w[19:18] = hh[5:4];
        w[23:20] = dd[3:0];  w[25:24] = dd[5:4];
        w[29:26] = mo[3:0];  w[30]    = mo[4];
        w[34:31] = yy[3:0];  w[38:35] = yy[7:4];
        w[41:39] = wd;       w[43:42] = tz;
        return w;
    endfunction

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic pulse_en();
        clk_en = 1'b1;
        tick();
        clk_en = 1'b0;
        tick();
    endtask

    task automatic wait_ack(input bit use_dcf, input string tag);
        bit got;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            tick();
            got = use_dcf ? dcf_ack_out : set_ack_out;
        end
        check_eq({tag, "_ack_seen"}, 64'(got), 64'd1);
    endtask

    initial begin
        w_set1     = mk_word(8'h23, 8'h59, 8'h45, 8'h31, 8'h12, 8'h19, 3'd2, 2'b01);
        w_dcf1     = mk_word(8'h12, 8'h30, 8'h00, 8'h15, 8'h06, 8'h21, 3'd3, 2'b10);
        w_bad_hr   = mk_word(8'h24, 8'h00, 8'h00, 8'h01, 8'h01, 8'h20, 3'd1, 2'b00);
        w_bad_min  = mk_word(8'h10, 8'h0A, 8'h00, 8'h01, 8'h01, 8'h20, 3'd1, 2'b00);
        w_dcf2     = mk_word(8'h08, 8'h15, 8'h30, 8'h28, 8'h02, 8'h24, 3'd5, 2'b00);
        w_set2     = mk_word(8'h00, 8'h00, 8'h00, 8'h01, 8'h01, 8'h00, 3'd7, 2'b11);
        w_dcf3     = mk_word(8'h19, 8'h45, 8'h59, 8'h30, 8'h11, 8'h22, 3'd4, 2'b00);
        w_feb29_19 = mk_word(8'h12, 8'h00, 8'h00, 8'h29, 8'h02, 8'h19, 3'd1, 2'b00);
        w_feb29_20 = mk_word(8'h12, 8'h00, 8'h00, 8'h29, 8'h02, 8'h20, 3'd6, 2'b00);
        w_feb31_19 = mk_word(8'h12, 8'h00, 8'h00, 8'h31, 8'h02, 8'h19, 3'd1, 2'b00);
        w_day00    = mk_word(8'h12, 8'h00, 8'h00, 8'h00, 8'h05, 8'h19, 3'd1, 2'b00);
        w_set3     = mk_word(8'h07, 8'h07, 8'h07, 8'h07, 8'h07, 8'h07, 3'd6, 2'b00);

        nReset = 1'b0; clk_en = 1'b0; DCF_Enable_in = 1'b0; dcf_req_in = 1'b0; set_req_in = 1'b0;
        DCF_timeAndDate_in = 44'd0; SetClock_timeAndDate_in = 44'd0;
        tick(); tick();
        check_eq("rst_strobe", 64'(clock_set_out), 64'd0);
        check_eq("rst_word", 64'(clock_timeAndDate_Out), 64'd0);
        check_eq("rst_source", 64'(source_out), 64'd0);
        check_eq("rst_acks", 64'({dcf_ack_out, set_ack_out, reject_out}), 64'd0);
        check_eq("rst_holdoff", 64'(holdoff_active_out), 64'd0);
        nReset = 1'b1;
        tick();

        // Manual set: strobe exactly two clocks after acceptance
        SetClock_timeAndDate_in = w_set1;
        set_req_in = 1'b1;
        tick();
        check_eq("set1_lat_c1", 64'(clock_set_out), 64'd0);
        tick();
        check_eq("set1_lat_c2", 64'(clock_set_out), 64'd0);
        tick();
        check_eq("set1_strobe", 64'(clock_set_out), 64'd1);
        check_eq("set1_ack", 64'({set_ack_out, dcf_ack_out}), 64'b10);
        check_eq("set1_word", 64'(clock_timeAndDate_Out), 64'(w_set1));
        check_eq("set1_source", 64'(source_out), 64'b10);
        check_eq("set1_holdoff", 64'(holdoff_active_out), 64'd1);
        set_req_in = 1'b0;
        tick();
        check_eq("set1_one_pulse", 64'({clock_set_out, set_ack_out}), 64'd0);

        // DCF blocked by hold-off until three clk_en pulses
        DCF_timeAndDate_in = w_dcf1;
        DCF_Enable_in = 1'b1;
        dcf_req_in = 1'b1;
        snap_a = n_dcf_ack;
        repeat (6) tick();
        check_eq("holdoff_block", 64'(n_dcf_ack - snap_a), 64'd0);
        pulse_en();
        pulse_en();
        check_eq("holdoff_after2", 64'(holdoff_active_out), 64'd1);
        clk_en = 1'b1;
        tick();
        clk_en = 1'b0;
        check_eq("holdoff_after3", 64'(holdoff_active_out), 64'd0);
        wait_ack(1'b1, "dcf1");
        check_eq("dcf1_strobe", 64'(clock_set_out), 64'd1);
        check_eq("dcf1_word", 64'(clock_timeAndDate_Out), 64'(w_dcf1));
        check_eq("dcf1_source", 64'(source_out), 64'b01);
        dcf_req_in = 1'b0;
        tick();

        // Invalid DCF words: reject with ack, output word retained
        DCF_timeAndDate_in = w_bad_hr;
        dcf_req_in = 1'b1;
        wait_ack(1'b1, "bad_hr");
        check_eq("bad_hr_reject", 64'({reject_out, clock_set_out}), 64'b10);
        check_eq("bad_hr_word", 64'(clock_timeAndDate_Out), 64'(w_dcf1));
        dcf_req_in = 1'b0;
        tick();
        DCF_timeAndDate_in = w_bad_min;
        dcf_req_in = 1'b1;
        wait_ack(1'b1, "bad_min");
        check_eq("bad_min_reject", 64'({reject_out, clock_set_out}), 64'b10);
        check_eq("bad_min_source", 64'(source_out), 64'b01);
        dcf_req_in = 1'b0;
        tick();

        // DCF disabled: request ignored for 100 cycles
        DCF_Enable_in = 1'b0;
        DCF_timeAndDate_in = w_dcf2;
        dcf_req_in = 1'b1;
        snap_a = n_dcf_ack;
        snap_b = n_strobe;
        repeat (100) tick();
        check_eq("dis_no_ack", 64'(n_dcf_ack - snap_a), 64'd0);
        check_eq("dis_no_strobe", 64'(n_strobe - snap_b), 64'd0);
        DCF_Enable_in = 1'b1;
        wait_ack(1'b1, "dcf2");
        check_eq("dcf2_strobe", 64'(clock_set_out), 64'd1);
        check_eq("dcf2_word", 64'(clock_timeAndDate_Out), 64'(w_dcf2));
        dcf_req_in = 1'b0;
        tick();

        // Simultaneous requests: SET wins, DCF waits for hold-off expiry and SET release
        SetClock_timeAndDate_in = w_set2;
        DCF_timeAndDate_in = w_dcf3;
        set_req_in = 1'b1;
        dcf_req_in = 1'b1;
        wait_ack(1'b0, "simul_set");
        check_eq("simul_set_word", 64'(clock_timeAndDate_Out), 64'(w_set2));
        check_eq("simul_set_source", 64'(source_out), 64'b10);
        check_eq("simul_no_dcf_ack", 64'(dcf_ack_out), 64'd0);
        snap_a = n_dcf_ack;
        pulse_en(); pulse_en(); pulse_en();
        tick(); tick();
        check_eq("simul_holdoff_gone", 64'(holdoff_active_out), 64'd0);
        check_eq("simul_dcf_waits_set", 64'(n_dcf_ack - snap_a), 64'd0);
        set_req_in = 1'b0;
        wait_ack(1'b1, "simul_dcf");
        check_eq("simul_dcf_word", 64'(clock_timeAndDate_Out), 64'(w_dcf3));
        check_eq("simul_dcf_source", 64'(source_out), 64'b01);
        dcf_req_in = 1'b0;
        tick();

        // Day range boundaries
        SetClock_timeAndDate_in = w_day00;
        set_req_in = 1'b1;
        wait_ack(1'b0, "day00");
        check_eq("day00_reject", 64'({reject_out, clock_set_out}), 64'b10);
        set_req_in = 1'b0;
        tick();
`ifdef TIME_LOAD_LEAP_CHECK_EN
        SetClock_timeAndDate_in = w_feb29_19;
        set_req_in = 1'b1;
        wait_ack(1'b0, "feb29_19");
        check_eq("feb29_19_reject", 64'({reject_out, clock_set_out}), 64'b10);
        set_req_in = 1'b0;
        tick();
        SetClock_timeAndDate_in = w_feb29_20;
        set_req_in = 1'b1;
        wait_ack(1'b0, "feb29_20");
        check_eq("feb29_20_load", 64'({reject_out, clock_set_out}), 64'b01);
        check_eq("feb29_20_word", 64'(clock_timeAndDate_Out), 64'(w_feb29_20));
        set_req_in = 1'b0;
        tick();
`else
        SetClock_timeAndDate_in = w_feb31_19;
        set_req_in = 1'b1;
        wait_ack(1'b0, "feb31_19");
        check_eq("feb31_19_load", 64'({reject_out, clock_set_out}), 64'b01);
        check_eq("feb31_19_word", 64'(clock_timeAndDate_Out), 64'(w_feb31_19));
        set_req_in = 1'b0;
        tick();
        SetClock_timeAndDate_in = w_feb29_19;
        set_req_in = 1'b1;
        wait_ack(1'b0, "feb29_19");
        check_eq("feb29_19_load", 64'({reject_out, clock_set_out}), 64'b01);
        set_req_in = 1'b0;
        tick();
`endif

        // Reset while in CHECK aborts; held request re-served afterwards
        SetClock_timeAndDate_in = w_set3;
        set_req_in = 1'b1;
        tick();
        nReset = 1'b0;
        #1;
        check_eq("midrst_word", 64'(clock_timeAndDate_Out), 64'd0);
        check_eq("midrst_outs", 64'({clock_set_out, set_ack_out, reject_out, holdoff_active_out, source_out}), 64'd0);
        snap_b = n_strobe;
        repeat (3) tick();
        check_eq("midrst_no_strobe", 64'(n_strobe - snap_b), 64'd0);
        nReset = 1'b1;
        wait_ack(1'b0, "midrst_reserve");
        check_eq("midrst_reserve_word", 64'(clock_timeAndDate_Out), 64'(w_set3));
        check_eq("midrst_reserve_source", 64'(source_out), 64'b10);
        set_req_in = 1'b0;
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
